sub_serial: RTL and testbench

- Bit-serial unsigned subtractor that computes D = A - B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the parallel 4-bit ripple adder in the arithmetic library.
- It is used in neuron datapaths where area matters more than latency, such as membrane-potential leak and threshold compare.
- It is driven by a start/done handshake from the neuron controller.

---
 rtl/sub_serial.sv | 154 +++++++++++++++
 tb/tb_sub_serial.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial : bit-serial unsigned subtractor, D = A - B, LSB first.
//
// One full-subtractor cell plus a borrow flip-flop processes one bit per
// clock. A start pulse in IDLE latches the operands. W clocks later the
// result is loaded into D/Bo and done pulses for one cycle. After that the
// block returns to IDLE.
//
// Optional build macro: SUB_SERIAL_SAT_EN
//   When defined, an underflow (final borrow = 1) loads D with 0 instead of
//   the wrapped difference. Bo still reports the borrow.
//
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset
//   start in  1  request pulse, honoured only in IDLE
//   A     in  W  minuend, captured on the accept edge
//   B     in  W  subtrahend, captured on the accept edge
//   busy  out 1  high while the serial operation runs
//   done  out 1  one-cycle pulse; D/Bo are valid while it is high
//   D     out W  difference, held until the next result is loaded
//   Bo    out 1  final borrow (A < B), held with D
// ---------------------------------------------------------------------------
module sub_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bo
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  ra, rb, res;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d_bit, br_nxt, last_bit;
  logic [W-1:0]  res_nxt, d_load;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
    logic d, bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  // Serial datapath: current bit, next borrow and next result register.
  always_comb begin
    {br_nxt, d_bit} = full_sub(ra[0], rb[0], br);
    last_bit        = (cnt == CW'(W - 1));
    // The new bit enters at the MSB; the oldest bit falls off the LSB.
    res_nxt         = W'({d_bit, res} >> 1);
`ifdef SUB_SERIAL_SAT_EN
    if (br_nxt) begin
      d_load = {W{1'b0}};
    end else begin
      d_load = res_nxt;
    end
`else
    d_load = res_nxt;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (last_bit) begin
          state_nxt = DONE;
        end else begin
          state_nxt = BUSY;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/result shift registers, borrow, bit counter and held outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra  <= {W{1'b0}};
      rb  <= {W{1'b0}};
      res <= {W{1'b0}};
      br  <= 1'b0;
      cnt <= {CW{1'b0}};
      D   <= {W{1'b0}};
      Bo  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= A;
            rb  <= B;
            res <= {W{1'b0}};
            br  <= 1'b0;
            cnt <= {CW{1'b0}};
          end
        end
        BUSY: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= res_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // D/Bo change only here, so they stay stable through later operations.
          if (last_bit) begin
            D  <= d_load;
            Bo <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sub_serial.sv
module tb_sub_serial;

  localparam int W = 4;

`ifdef SUB_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] D;
  logic         Bo;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_d = '0;

  sub_serial #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Bo(Bo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;   // wrapped difference
    logic       bo;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_d(input logic [3:0] d, input logic bo);
    return (SAT && bo) ? 4'd0 : d;
  endfunction

  // One operation: start on the next IDLE cycle, wait for done, check result,
  // occupancy and that D held its old value until the done pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb, input string nm);
    int occ;
    bit seen;
    bit held;
    @(negedge clk);
    chk({nm, " idle"}, {30'd0, busy, done}, 32'd0);
    chk({nm, " hold"}, {28'd0, D}, {28'd0, last_d});
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    A = 4'($urandom);
    B = 4'($urandom);
    occ = 0; seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy || done) occ++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (D !== last_d) held = 1'b0;
        @(negedge clk);
      end
    end
    chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " D stable while busy"}, {31'd0, held}, 32'd1);
    chk({nm, " occupancy"}, occ, W + 1);
    chk({nm, " D"}, {28'd0, D}, {28'd0, ed});
    chk({nm, " Bo"}, {31'd0, Bo}, {31'd0, eb});
    last_d = ed;
  endtask

  initial begin
    int dcnt;
    int dcyc;
    logic [3:0] dval;
    logic       bval;

    tbl[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
    tbl[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
    tbl[2] = '{4'd15, 4'd15, 4'd0,  1'b0};
    tbl[3] = '{4'd0,  4'd0,  4'd0,  1'b0};
    tbl[4] = '{4'd0,  4'd15, 4'd1,  1'b1};
    tbl[5] = '{4'd15, 4'd0,  4'd15, 1'b0};
    tbl[6] = '{4'd1,  4'd2,  4'd15, 1'b1};
    tbl[7] = '{4'd12, 4'd5,  4'd7,  1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #2;
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    chk("reset D/Bo", {27'd0, Bo, D}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, exp_d(tbl[i].d, tbl[i].bo), tbl[i].bo, $sformatf("vec%0d", i));
    end

    // start during BUSY is ignored: one done, original schedule and result.
    @(negedge clk);
    start = 1'b1; A = 4'd9; B = 4'd3;
    @(negedge clk);   // first BUSY cycle
    start = 1'b0;
    dcnt = 0; dcyc = 0; dval = '0; bval = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin start = 1'b1; A = 4'd1; B = 4'd1; end
      if (c == 3) start = 1'b0;
      if (done) begin
        dcnt++;
        if (dcyc == 0) begin dcyc = c; dval = D; bval = Bo; end
      end
      @(negedge clk);
    end
    chk("ignore done count", dcnt, 1);
    chk("ignore done cycle", dcyc, W + 1);
    chk("ignore D", {28'd0, dval}, 32'd6);
    chk("ignore Bo", {31'd0, bval}, 32'd0);
    last_d = 4'd6;

    // Reset two cycles into a 9-3 operation.
    start = 1'b1; A = 4'd9; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset busy/done", {30'd0, busy, done}, 32'd0);
    chk("midreset D/Bo", {27'd0, Bo, D}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("midreset no done", dcnt, 0);
    last_d = 4'd0;
    run_op(4'd7, 4'd2, 4'd5, 1'b0, "after reset 7-2");

    // Exhaustive back-to-back sweep against an arithmetic model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] wd;
        logic       wb;
        wd = 4'((a - b) & 15);
        wb = (a < b);
        run_op(4'(a), 4'(b), exp_d(wd, wb), wb, $sformatf("sweep %0d-%0d", a, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
